// File: rtl/jogo_pkg.sv
// Shared state codes, output bundle and default timing for the memory-game control unit.
package jogo_pkg;

    localparam int unsigned SHOW_CYCLES_DEF    = 1000;
    localparam int unsigned GAP_CYCLES_DEF     = 250;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 5000;

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        INICIA_RODADA  = 4'h2,
        MOSTRA         = 4'h3,
        APAGA          = 4'h4,
        PROXIMO_MOSTRA = 4'h5,
        FIM_MOSTRA     = 4'h6,
        ESPERA_JOGADA  = 4'h7,
        REGISTRA       = 4'h8,
        COMPARA        = 4'h9,
        PROXIMA_JOGADA = 4'hA,
        PROXIMA_RODADA = 4'hB,
        FIM_TIMEOUT    = 4'hD,
        FIM_ERROU      = 4'hE,
        FIM_GANHOU     = 4'hF
    } estado_t;

    typedef struct packed {
        logic zeraE;
        logic contaE;
        logic zeraR;
        logic contaR;
        logic registraR;
        logic mostraLeds;
        logic pronto;
        logic ganhou;
        logic perdeu;
        logic db_timeout;
    } saidas_t;

    // Moore output decode for a given state.
    function automatic saidas_t decodifica(estado_t e);
        saidas_t s;
        s = '0;
        case (e)
            PREPARACAO:     begin s.zeraE = 1'b1; s.zeraR = 1'b1; end
            INICIA_RODADA:  s.zeraE = 1'b1;
            MOSTRA:         s.mostraLeds = 1'b1;
            PROXIMO_MOSTRA: s.contaE = 1'b1;
            FIM_MOSTRA:     s.zeraE = 1'b1;
            REGISTRA:       s.registraR = 1'b1;
            PROXIMA_JOGADA: s.contaE = 1'b1;
            PROXIMA_RODADA: s.contaR = 1'b1;
            FIM_TIMEOUT:    begin s.pronto = 1'b1; s.perdeu = 1'b1; s.db_timeout = 1'b1; end
            FIM_ERROU:      begin s.pronto = 1'b1; s.perdeu = 1'b1; end
            FIM_GANHOU:     begin s.pronto = 1'b1; s.ganhou = 1'b1; end
            default:        s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/unidade_controle_jogo_if.sv
// Strobe/status bundle between the game control unit (master) and the datapath/top (slave).
interface unidade_controle_jogo_if;
    logic       iniciar;
    logic       jogada;
    logic       igual;
    logic       enderecoIgualRodada;
    logic       fimRodadas;
    logic       zeraE;
    logic       contaE;
    logic       zeraR;
    logic       contaR;
    logic       registraR;
    logic       mostraLeds;
    logic       pronto;
    logic       ganhou;
    logic       perdeu;
    logic       db_timeout;
    logic [3:0] db_estado;

    modport master (
        input  iniciar, jogada, igual, enderecoIgualRodada, fimRodadas,
        output zeraE, contaE, zeraR, contaR, registraR, mostraLeds,
               pronto, ganhou, perdeu, db_timeout, db_estado
    );

    modport slave (
        output iniciar, jogada, igual, enderecoIgualRodada, fimRodadas,
        input  zeraE, contaE, zeraR, contaR, registraR, mostraLeds,
               pronto, ganhou, perdeu, db_timeout, db_estado
    );
endinterface

// File: rtl/contador_timer.sv
// Saturating up-counter; fim flags the terminal count M-1, zera has priority over conta.
module contador_timer #(
    parameter int unsigned M = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);
    localparam int unsigned W = (M > 1) ? $clog2(M) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)              cnt <= '0;
        else if (zera)           cnt <= '0;
        else if (conta && !fim)  cnt <= cnt + W'(1);
    end

    assign fim = (cnt == W'(M - 1));
endmodule

// File: rtl/unidade_controle_jogo.sv
// Memory-game control unit: Moore FSM with show/gap/timeout timers.
// Define GAME_TIMEOUT_EN to build the per-press timeout (state D reachable).
module unidade_controle_jogo
    import jogo_pkg::*;
#(
    parameter int unsigned SHOW_CYCLES    = SHOW_CYCLES_DEF,
    parameter int unsigned GAP_CYCLES     = GAP_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                    clock,
    input  logic                    reset,
    unidade_controle_jogo_if.master bus
);
    estado_t estado, estado_next;
    saidas_t saidas, saidas_next;
    logic    fim_show, fim_gap, fim_timeout;

    // Each timer is held at zero outside its owning state.
    contador_timer #(.M(SHOW_CYCLES)) u_show (
        .clock (clock), .reset (reset),
        .zera  (estado != MOSTRA), .conta (estado == MOSTRA),
        .fim   (fim_show)
    );

    contador_timer #(.M(GAP_CYCLES)) u_gap (
        .clock (clock), .reset (reset),
        .zera  (estado != APAGA), .conta (estado == APAGA),
        .fim   (fim_gap)
    );

`ifdef GAME_TIMEOUT_EN
    contador_timer #(.M(TIMEOUT_CYCLES)) u_timeout (
        .clock (clock), .reset (reset),
        .zera  (estado != ESPERA_JOGADA), .conta (estado == ESPERA_JOGADA),
        .fim   (fim_timeout)
    );
`else
    // No timeout timer: the player may wait indefinitely.
    if (TIMEOUT_CYCLES != 0) begin : g_sem_timeout
        assign fim_timeout = 1'b0;
    end else begin : g_sem_timeout_zero
        assign fim_timeout = 1'b0;
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= INICIAL;
            saidas <= '0;
        end else begin
            estado <= estado_next;
            saidas <= saidas_next;
        end
    end

    always_comb begin
        estado_next = estado;
        case (estado)
            INICIAL:        if (bus.iniciar) estado_next = PREPARACAO;
            PREPARACAO:     estado_next = INICIA_RODADA;
            INICIA_RODADA:  estado_next = MOSTRA;
            MOSTRA:         if (fim_show) estado_next = APAGA;
            APAGA:
                if (fim_gap)
                    estado_next = bus.enderecoIgualRodada ? FIM_MOSTRA : PROXIMO_MOSTRA;
            PROXIMO_MOSTRA: estado_next = MOSTRA;
            FIM_MOSTRA:     estado_next = ESPERA_JOGADA;
            ESPERA_JOGADA:
                if (bus.jogada)       estado_next = REGISTRA;
                else if (fim_timeout) estado_next = FIM_TIMEOUT;
            REGISTRA:       estado_next = COMPARA;
            COMPARA:
                if (!bus.igual)                    estado_next = FIM_ERROU;
                else if (!bus.enderecoIgualRodada) estado_next = PROXIMA_JOGADA;
                else if (bus.fimRodadas)           estado_next = FIM_GANHOU;
                else                               estado_next = PROXIMA_RODADA;
            PROXIMA_JOGADA: estado_next = ESPERA_JOGADA;
            PROXIMA_RODADA: estado_next = INICIA_RODADA;
            FIM_TIMEOUT, FIM_ERROU, FIM_GANHOU:
                if (bus.iniciar) estado_next = PREPARACAO;
            default:        estado_next = INICIAL;
        endcase

        // Outputs are registered alongside the state so they track it exactly.
        saidas_next = decodifica(estado_next);
`ifndef GAME_TIMEOUT_EN
        saidas_next.db_timeout = 1'b0;
`endif
    end

    assign bus.zeraE      = saidas.zeraE;
    assign bus.contaE     = saidas.contaE;
    assign bus.zeraR      = saidas.zeraR;
    assign bus.contaR     = saidas.contaR;
    assign bus.registraR  = saidas.registraR;
    assign bus.mostraLeds = saidas.mostraLeds;
    assign bus.pronto     = saidas.pronto;
    assign bus.ganhou     = saidas.ganhou;
    assign bus.perdeu     = saidas.perdeu;
    assign bus.db_timeout = saidas.db_timeout;
    assign bus.db_estado  = estado;
endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Directed bench for unidade_controle_jogo with short timing (show 4, gap 2, timeout 10).
module tb_unidade_controle_jogo;
    logic clock;
    logic reset;
    int   checks;
    int   failures;

    unidade_controle_jogo_if bus ();

    unidade_controle_jogo #(
        .SHOW_CYCLES    (4),
        .GAP_CYCLES     (2),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // {zeraE,contaE,zeraR,contaR,registraR,mostraLeds,pronto,ganhou,perdeu,db_timeout}
    logic [9:0] obs_saidas;
    assign obs_saidas = {bus.zeraE, bus.contaE, bus.zeraR, bus.contaR, bus.registraR,
                         bus.mostraLeds, bus.pronto, bus.ganhou, bus.perdeu, bus.db_timeout};

    localparam logic [9:0] O_NADA = 10'b0000000000;
    localparam logic [9:0] O_PREP = 10'b1010000000;
    localparam logic [9:0] O_ZE   = 10'b1000000000;
    localparam logic [9:0] O_MOST = 10'b0000010000;
    localparam logic [9:0] O_CE   = 10'b0100000000;
    localparam logic [9:0] O_REG  = 10'b0000100000;
    localparam logic [9:0] O_CR   = 10'b0001000000;
    localparam logic [9:0] O_TOUT = 10'b0000001011;
    localparam logic [9:0] O_ERR  = 10'b0000001010;
    localparam logic [9:0] O_WIN  = 10'b0000001100;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic expect_st(input string tag, input logic [3:0] code, input logic [9:0] outs);
        chk({tag, "_estado"}, {6'b0, bus.db_estado}, {6'b0, code});
        chk({tag, "_saidas"}, obs_saidas, outs);
    endtask

    // From the first cycle of state 3 with enderecoIgualRodada=1: 4 shown, 2 dark, 6, then 7.
    task automatic to_espera(input string tag);
        repeat (7) tick();
        expect_st(tag, 4'h7, O_NADA);
    endtask

    initial begin
        int n;
        checks   = 0;
        failures = 0;
        reset = 1'b0;
        bus.iniciar = 1'b0;
        bus.jogada = 1'b0;
        bus.igual = 1'b0;
        bus.enderecoIgualRodada = 1'b1;
        bus.fimRodadas = 1'b0;

        tick();
        expect_st("reset", 4'h0, O_NADA);
        reset = 1'b1;
        tick();
        expect_st("idle", 4'h0, O_NADA);

        bus.iniciar = 1'b1;
        tick();
        expect_st("prep", 4'h1, O_PREP);
        bus.iniciar = 1'b0;
        tick();
        expect_st("inicia", 4'h2, O_ZE);
        tick();
        expect_st("mostra", 4'h3, O_MOST);

        // Count lit cycles from entry into state 3.
        n = 0;
        while (bus.mostraLeds && n < 20) begin
            n++;
            tick();
        end
        chk("show_len", 10'(n), 10'd4);
        expect_st("apaga1", 4'h4, O_NADA);
        tick();
        expect_st("apaga2", 4'h4, O_NADA);
        tick();
        expect_st("fim_mostra", 4'h6, O_ZE);
        tick();
        expect_st("espera", 4'h7, O_NADA);

        // Correct last press of round 0.
        bus.igual = 1'b1;
        bus.jogada = 1'b1;
        tick();
        expect_st("registra", 4'h8, O_REG);
        bus.jogada = 1'b0;
        tick();
        expect_st("compara", 4'h9, O_NADA);
        tick();
        expect_st("prox_rodada", 4'hB, O_CR);
        tick();
        expect_st("nova_rodada", 4'h2, O_ZE);

        // Round 1: first display entry is not the last one.
        bus.enderecoIgualRodada = 1'b0;
        tick();
        expect_st("r1_mostra", 4'h3, O_MOST);
        repeat (6) tick();
        expect_st("r1_prox_mostra", 4'h5, O_CE);
        tick();
        expect_st("r1_mostra2", 4'h3, O_MOST);
        bus.enderecoIgualRodada = 1'b1;
        to_espera("r1_espera");

        // First press of round 1 is correct but not the last.
        bus.enderecoIgualRodada = 1'b0;
        bus.jogada = 1'b1;
        tick();
        bus.jogada = 1'b0;
        tick();
        tick();
        expect_st("prox_jogada", 4'hA, O_CE);
        tick();
        expect_st("r1_espera2", 4'h7, O_NADA);
        bus.enderecoIgualRodada = 1'b1;
        bus.jogada = 1'b1;
        tick();
        bus.jogada = 1'b0;
        repeat (3) tick();
        expect_st("r2_inicia", 4'h2, O_ZE);
        tick();
        expect_st("r2_mostra", 4'h3, O_MOST);

        // Asynchronous reset in the middle of the display.
        #2 reset = 1'b0;
        #1;
        expect_st("async_reset", 4'h0, O_NADA);
        #2 reset = 1'b1;
        tick();
        expect_st("pos_reset", 4'h0, O_NADA);
        bus.iniciar = 1'b1;
        tick();
        expect_st("re_prep", 4'h1, O_PREP);
        bus.iniciar = 1'b0;
        tick();
        expect_st("re_inicia", 4'h2, O_ZE);
        tick();
        expect_st("re_mostra", 4'h3, O_MOST);
        to_espera("re_espera");

        // Wrong press.
        bus.igual = 1'b0;
        bus.jogada = 1'b1;
        tick();
        bus.jogada = 1'b0;
        tick();
        tick();
        expect_st("errou", 4'hE, O_ERR);
        tick();
        expect_st("errou_hold", 4'hE, O_ERR);
        bus.iniciar = 1'b1;
        tick();
        expect_st("errou_restart", 4'h1, O_PREP);
        bus.iniciar = 1'b0;
        tick();
        tick();
        expect_st("pos_erro_mostra", 4'h3, O_MOST);
        to_espera("pos_erro_espera");

`ifdef GAME_TIMEOUT_EN
        repeat (9) tick();
        expect_st("quase_timeout", 4'h7, O_NADA);
        tick();
        expect_st("timeout", 4'hD, O_TOUT);
        bus.iniciar = 1'b1;
        tick();
        expect_st("timeout_restart", 4'h1, O_PREP);
        bus.iniciar = 1'b0;
        tick();
        tick();
        to_espera("to_espera2");
        repeat (9) tick();
        bus.jogada = 1'b1;
        tick();
        expect_st("jogada_prioridade", 4'h8, O_REG);
        bus.jogada = 1'b0;
`else
        repeat (50) tick();
        expect_st("sem_timeout", 4'h7, O_NADA);
        bus.jogada = 1'b1;
        tick();
        expect_st("registra_tardio", 4'h8, O_REG);
        bus.jogada = 1'b0;
`endif

        // Final press of the last round.
        bus.igual = 1'b1;
        bus.enderecoIgualRodada = 1'b1;
        bus.fimRodadas = 1'b1;
        tick();
        tick();
        expect_st("ganhou", 4'hF, O_WIN);
        tick();
        expect_st("ganhou_hold", 4'hF, O_WIN);
        bus.iniciar = 1'b1;
        tick();
        expect_st("ganhou_restart", 4'h1, O_PREP);
        bus.iniciar = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/unidade_controle_jogo.md
Name: unidade_controle_jogo

Overview:
Control unit (Moore FSM plus two internal timers) that sequences the memory-game datapath of circuito_exp6. Each round it replays the stored LED sequence up to the current round, then waits for and checks the player's presses one at a time. It drives counter/register strobes into the datapath and the pronto/ganhou/perdeu flags out to the top level. It also enforces per-press timeout and LED on/off display timing.

Parameters:
SHOW_CYCLES, 1000, clock cycles each sequence LED stays lit (1 s at 1 kHz)
GAP_CYCLES, 250, clock cycles LEDs stay dark between displayed entries
TIMEOUT_CYCLES, 5000, max cycles allowed per press before loss (5 s)

Ports:
clock  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-low (0 = reset); the only reset
iniciar  in  1  start/restart request, level
jogada  in  1  one-cycle pulse from datapath edge detector: a button press was made
igual  in  1  registered press equals memory[endereco]
enderecoIgualRodada  in  1  address counter == round counter
fimRodadas  in  1  round counter at last round (15)
zeraE  out  1  clear address counter
contaE  out  1  increment address counter
zeraR  out  1  clear round counter
contaR  out  1  increment round counter
registraR  out  1  load press register
mostraLeds  out  1  drive leds from memory output (else leds = botoes)
pronto  out  1  game finished
ganhou  out  1  finished by winning
perdeu  out  1  finished by error or timeout
db_timeout  out  1  high in fim_timeout state
db_estado  out  4  current state code

Behaviour:
- All outputs Moore-decoded from the registered state; reset forces inicial (all outputs 0, db_estado=0) immediately and asynchronously, from any state; both timers cleared.
- States (hex code): 0 inicial, 1 preparacao, 2 inicia_rodada, 3 mostra, 4 apaga, 5 proximo_mostra, 6 fim_mostra, 7 espera_jogada, 8 registra, 9 compara, A proxima_jogada, B proxima_rodada, D fim_timeout, E fim_errou, F fim_ganhou. Code C unused; decode -> inicial.
- 0: iniciar -> 1. Outputs all 0.
- 1: zeraE, zeraR -> 2.
- 2: zeraE -> 3.
- 3: mostraLeds=1; show timer counts 0..SHOW_CYCLES-1; at terminal count -> 4 (exactly SHOW_CYCLES cycles in 3).
- 4: gap timer counts 0..GAP_CYCLES-1; at terminal: enderecoIgualRodada -> 6, else -> 5.
- 5: contaE -> 3.   6: zeraE -> 7.
- 7: timeout counter counts; jogada -> 8; else count==TIMEOUT_CYCLES-1 -> D. Same-cycle jogada and timeout: jogada wins.
- 8: registraR -> 9.
- 9: !igual -> E; igual & enderecoIgualRodada & fimRodadas -> F; igual & enderecoIgualRodada -> B; igual -> A.
- A: contaE -> 7.   B: contaR -> 2.
- D: pronto, perdeu, db_timeout. E: pronto, perdeu. F: pronto, ganhou. In D/E/F iniciar -> 1, else hold.
- Timers: widths $clog2(param); each held at 0 whenever not in its owning state (show: 3, gap: 4, timeout: 7); so every entry restarts from 0. No wrap beyond terminal count.
- iniciar ignored in states 1..B.

Optional Feature:
Macro GAME_TIMEOUT_EN. Defined: timeout counter and transition 7->D present as above. Undefined: no timeout counter synthesized, state 7 waits indefinitely for jogada, db_timeout tied 0, state D unreachable.

Decomposition:
- Package jogo_pkg: 4-bit state codes (localparams/typedef), default timing constants.
- One sub-module natural: contador_timer (parameterized M, inputs clock/reset/zera/conta, output fim at M-1), instantiated three times.

Test Plan (SHOW_CYCLES=4, GAP_CYCLES=2, TIMEOUT_CYCLES=10):
- Reset low mid-game (state 3) -> db_estado=0, all outputs 0 same cycle, mostraLeds 0; iniciar pulse after release -> 1,2,3.
- Round 0 display: from entering 3, mostraLeds high exactly 4 cycles, then 2 dark cycles, then 6 -> 7 (enderecoIgualRodada=1).
- Correct press (igual=1, enderecoIgualRodada=1, fimRodadas=0) -> 8,9,B, one contaR pulse, back to 2.
- Wrong press (igual=0) -> E; pronto=1, perdeu=1, ganhou=0; iniciar -> 1 with zeraE/zeraR.
- No press for 10 cycles in 7 -> D, db_timeout=1; repeat with jogada on cycle 10 -> 8 instead (jogada priority).
- Last press with fimRodadas=1 -> F, ganhou=1; with GAME_TIMEOUT_EN undefined, 50 idle cycles in 7 stay in 7.
